// File: rtl/approx_seq_mul.sv
// Multi-cycle shift-add unsigned multiplier with a runtime exact/approximate mode.
// Approximate mode drops the low TRUNC partial-product columns and adds COMP, saturating.
module approx_seq_mul #(
  parameter int                 WIDTH = 6,
  parameter int                 TRUNC = 4,
  parameter logic [2*WIDTH-1:0] COMP  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 p_approx,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             approx_q, approx_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic             p_approx_q, p_approx_d;

  logic [PW-1:0]    mask;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_sum;
  logic [PW:0]      comp_sum;
  logic [PW-1:0]    approx_result;
  logic             last_step;

  // Truncated columns are masked off only while the captured mode is approximate.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_mask
      assign mask[gi] = !(approx_q && (gi < TRUNC));
    end
  endgenerate

  assign pp        = b_q[cnt_q] ? ((({{WIDTH{1'b0}}, a_q}) << cnt_q) & mask) : '0;
  assign acc_sum   = acc_q + pp;
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign comp_sum  = {1'b0, acc_sum} + {1'b0, COMP};

  always_comb begin
    approx_result = '0;
    if (a_q != '0 && b_q != '0) begin
      approx_result = comp_sum[PW] ? '1 : comp_sum[PW-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    approx_d   = approx_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    p_approx_d = p_approx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          approx_d = approx_en;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          cnt_d      = '0;
          p_d        = approx_q ? approx_result : acc_sum;
          p_approx_d = approx_q;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      approx_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      p_q        <= '0;
      p_approx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      approx_q   <= approx_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      p_approx_q <= p_approx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign p         = p_q;
  assign p_approx  = p_approx_q;

endmodule
